// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline (priority) and a read-only debug port.
// Uncontested debug ack next cycle; contested requests force a one-cycle pipeline stall after STARVE_MAX+1 lost cycles.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE, ACK} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
    logic              dbg_own;
    logic              grant;

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        dbg_own        = 1'b0;
        grant          = 1'b0;
        pipe_stall     = 1'b0;
        case (state)
            IDLE: begin
                starve_cnt_nxt = '0;
                if (dbg_req && !pipe_req) begin
                    dbg_own   = 1'b1;
                    grant     = 1'b1;
                    state_nxt = ACK;
                end else if (dbg_req) begin
                    state_nxt      = WAIT;
                    starve_cnt_nxt = CNT_W'(1);
                end
            end
            WAIT: begin
                if (!dbg_req) begin
                    state_nxt      = IDLE;
                    starve_cnt_nxt = '0;
                end else if (!pipe_req) begin
                    dbg_own        = 1'b1;
                    grant          = 1'b1;
                    state_nxt      = ACK;
                    starve_cnt_nxt = '0;
                end else if (starve_cnt == CNT_W'(STARVE_MAX)) begin
                    state_nxt = FORCE;
                end else begin
                    starve_cnt_nxt = starve_cnt + CNT_W'(1);
                end
            end
            FORCE: begin
                // Pipeline access this cycle is dropped; it replays once the stall lifts.
                dbg_own        = 1'b1;
                grant          = 1'b1;
                pipe_stall     = 1'b1;
                state_nxt      = ACK;
                starve_cnt_nxt = '0;
            end
            ACK: begin
                state_nxt      = IDLE;
                starve_cnt_nxt = '0;
            end
            default: begin
                state_nxt      = IDLE;
                starve_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            dbg_ack    <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            dbg_ack    <= grant;
            if (grant) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr   = dbg_own ? dbg_addr : pipe_addr;
    assign mem_we     = !dbg_own && pipe_req && pipe_we;
    assign mem_wdata  = pipe_wdata;
    assign pipe_rdata = mem_rdata;

endmodule
